// File: rtl/seq_divider32.sv
// Iterative restoring divider: one quotient bit per clock, unsigned by default.
// Define DIV_SIGNED_EN to add the signed_op port and two's-complement operation.
module seq_divider32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r, q, dvsr;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   sum;
    logic             no_borrow;
    logic [WIDTH-1:0] r_new, q_new, q_fin, r_fin;
    logic             accept, ld_zero, ld_run, busy_nxt, done_nxt;

    // Operand magnitudes fed to the unsigned core
`ifdef DIV_SIGNED_EN
    logic sa, sb, neg_q, neg_r;
    assign sa    = signed_op & dividend[WIDTH-1];
    assign sb    = signed_op & divisor[WIDTH-1];
    assign mag_a = sa ? (~dividend + WIDTH'(1)) : dividend;
    assign mag_b = sb ? (~divisor + WIDTH'(1)) : divisor;
`else
    assign mag_a = dividend;
    assign mag_b = divisor;
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Trial subtraction: carry-out of R_low + ~D + 1 means no borrow. The shifted-out
    // remainder MSB alone also guarantees no borrow since R < D < 2^WIDTH.
    assign r_sh      = {r, q[WIDTH-1]};
    assign sum       = {1'b0, r_sh[WIDTH-1:0]} + {1'b0, ~dvsr} + (WIDTH+1)'(1);
    assign no_borrow = r_sh[WIDTH] | sum[WIDTH];
    assign r_new     = no_borrow ? sum[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign q_new     = {q[WIDTH-2:0], no_borrow};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (divisor == '0) ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            RUN:     if (cnt == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
        ld_zero  = accept && (divisor == '0);
        ld_run   = (state == RUN) && (cnt == '0);
        q_fin    = q_new;
        r_fin    = r_new;
`ifdef DIV_SIGNED_EN
        if (neg_q) q_fin = ~q_new + WIDTH'(1);
        if (neg_r) r_fin = ~r_new + WIDTH'(1);
`endif
    end

    // Iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            dvsr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (accept) begin
                cnt         <= CW'(WIDTH - 1);
                r           <= '0;
                q           <= mag_a;
                dvsr        <= mag_b;
                div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                neg_q       <= sa ^ sb;
                neg_r       <= sa;
`endif
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
                r   <= r_new;
                q   <= q_new;
            end
            if (ld_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else if (ld_run) begin
                quotient    <= q_fin;
                remainder   <= r_fin;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider32.sv
// Directed bench for seq_divider32: latency, results, divide-by-zero, ignored start,
// back-to-back start, mid-run reset, and the signed build when DIV_SIGNED_EN is set.
module tb_seq_divider32;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
`ifdef DIV_SIGNED_EN
    logic        signed_op;
`endif
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    seq_divider32 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef DIV_SIGNED_EN
        .signed_op  (signed_op),
`endif
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start an operation at this negedge, optionally poke start at cycle 'inject', wait for done.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int inject, input int exp_lat,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
        int cyc;
        int nbusy;
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h0BAD_F00D;
        cyc = 1;
        nbusy = 0;
        while (!done && cyc < 100) begin
            if (busy) nbusy++;
            if (cyc == inject) begin
                start = 1'b1; dividend = 32'd5; divisor = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy"}, 32'(nbusy), 32'(exp_lat - 1));
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("d100_7", 32'd100, 32'd7, 0, 33, 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        check("pulse_done", 32'(done), 32'd0);
        check("hold_q", quotient, 32'd14);

        do_op("max_1", 32'hFFFF_FFFF, 32'd1, 0, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
        @(negedge clk);
        do_op("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33, 32'd1, 32'd0, 1'b0);
        @(negedge clk);
        do_op("dbz", 32'h1234, 32'd0, 0, 1, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        @(negedge clk);

        // In-flight start ignored, then back-to-back start in the DONE cycle
        do_op("ign", 32'd100, 32'd7, 5, 33, 32'd14, 32'd2, 1'b0);
        do_op("b2b", 32'd9, 32'd4, 0, 33, 32'd2, 32'd1, 1'b0);
        @(negedge clk);

        // Reset at cycle 10 of a run
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_q", quotient, 32'd0);
        check("mrst_r", remainder, 32'd0);
        check("mrst_dbz", 32'(div_by_zero), 32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        check("mrst_idle", 32'(seen), 32'd0);
        do_op("d50_5", 32'd50, 32'd5, 0, 33, 32'd10, 32'd0, 1'b0);
        @(negedge clk);

`ifdef DIV_SIGNED_EN
        signed_op = 1'b1;
        do_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        do_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, 33, 32'h8000_0000, 32'd0, 1'b0);
        @(negedge clk);
        signed_op = 1'b0;
`endif

        check("busy_done_overlap", 32'(overlap), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
